rename_checkpoint_unit: RTL and testbench
=========================================

# rename_checkpoint_unit

Parametrised register-rename unit sitting between decode and the instruction queue. It holds a register map table (RMT), a circular free list, a busy-bit table and a stack of branch checkpoints. Each cycle it renames up to one instruction and snapshots the map on branches. On a mispredict it restores the map and free-list head in one cycle, and it returns old physical registers to the free list on commit.

## Interface

Parameters:
- NUM_ARCH_REGS, 32, architectural registers; reg 0 is renamed like any other.
- NUM_PHYS_REGS, 64, physical registers; must exceed NUM_ARCH_REGS.
- NUM_CKPTS, 4, branch checkpoint slots; power of two.
- Derived: AW = clog2(NUM_ARCH_REGS), PW = clog2(NUM_PHYS_REGS), CW = clog2(NUM_CKPTS).

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- ren_valid  in  1  rename request this cycle.
- ren_uses_rw  in  1  instruction writes a destination.
- ren_ckpt  in  1  instruction is a branch; take a checkpoint.
- ren_rs_arch, ren_rt_arch, ren_rw_arch  in  AW each  source and destination arch regs.
- ren_ready  out  1  combinational; request accepted iff ren_valid and ren_ready.
- out_valid  out  1  registered; renamed result valid.
- out_rs_phys, out_rt_phys, out_rw_phys, out_old_phys  out  PW each  renamed regs; out_old_phys is the previous mapping of rw.
- out_rs_busy, out_rt_busy  out  1 each  source not yet written back.
- out_ckpt_id  out  CW  checkpoint slot taken (valid when the request had ren_ckpt).
- wb_valid, wb_phys  in  1, PW  writeback; clears the busy bit.
- cm_valid, cm_old_phys  in  1, PW  commit; pushes cm_old_phys onto the free list.
- br_valid, br_mispredict, br_ckpt_id  in  1, 1, CW  branch resolution.
- free_count  out  PW+1  free-list occupancy.
- ckpt_count  out  CW+1  live checkpoints.

## Operation

- Reset: RMT[i]=i. Free list holds NUM_ARCH_REGS..NUM_PHYS_REGS-1 in ascending order (rd_ptr=0, wr_ptr=NUM_PHYS_REGS-NUM_ARCH_REGS). Busy table all 0. Checkpoint stack empty. All outputs 0; free_count=NUM_PHYS_REGS-NUM_ARCH_REGS, ckpt_count=0.
- Free list: NUM_PHYS_REGS entries, PW+1-bit pointers with a wrap bit. free_count = wr_ptr - rd_ptr.
- ren_ready = !(br_valid & br_mispredict) & (!ren_uses_rw | free_count!=0) & (!ren_ckpt | ckpt_count!=NUM_CKPTS).
- Accepted rename:
  - Sources read the RMT before this instruction's own update, so r1=r1+r2 reads the old r1.
  - If uses_rw: pop the free-list head into out_rw_phys, set out_old_phys=RMT[rw], write RMT[rw]=new, set busy[new]=1.
  - If !uses_rw: out_rw_phys=out_old_phys=0 and no pop.
- Checkpoint: the slot at ckpt_tail stores the post-rename RMT (including this instruction's update) and the post-pop rd_ptr. out_ckpt_id=ckpt_tail, then tail++.
- Correct resolve (br_valid & !br_mispredict): br_ckpt_id must equal ckpt_head (in-order resolution). head++.
- Mispredict: RMT := ckpt[id].rmt, rd_ptr := ckpt[id].rd_ptr, ckpt_tail := id+1. Younger checkpoints are discarded; the mispredicting branch's checkpoint stays live until its correct resolve is presented or a later flush. wr_ptr is untouched.
- Writeback: busy[wb_phys]=0.
- Commit: free[wr_ptr]=cm_old_phys, wr_ptr++. Committing when free_count==NUM_PHYS_REGS is illegal (assertion).
- Busy bits of squashed allocations are not cleared; they are reset when reallocated.

## Timing

- Rename latency 1 cycle: out_* registered, out_valid=1 the cycle after acceptance and 0 otherwise.
- Busy bypass: wb_valid with wb_phys equal to a renamed source in the same cycle gives out_*_busy=0.
- Rename set and writeback clear of the same phys in the same cycle: the set wins.
- Commit and rename in the same cycle with free_count==0: the rename stalls (ren_ready uses the pre-commit count). The pushed reg becomes poppable next cycle.
- Mispredict and commit in the same cycle: rd_ptr is restored and wr_ptr increments; both take effect.
- Mispredict and rename in the same cycle: the rename is rejected. The restored map is visible to renames the following cycle.
- rst mid-operation: all state returns to reset values next edge; out_valid=0.

## Test plan

- Reset, then rename add r3<-r1,r2 -> next cycle out_rs_phys=1, out_rt_phys=2, out_rw_phys=32, out_old_phys=3, free_count=31.
- Rename r5<-r5,r0, then read r5 -> first gives out_rs_phys=5, second gives out_rs_phys=32 with out_rs_busy=1. wb_phys=32 in the same cycle as the second -> busy=0.
- Rename 32 writers with no commits -> ren_ready=0 on the 33rd. cm_old_phys=3 -> the next rename gets phys 3.
- Branch checkpoint after r1->32, then rename r1->33, r2->34. Mispredict id 0 -> next rename of r1 reads 32 and allocates 33 again; ckpt_count=1.
- Fill NUM_CKPTS=4 branches -> ren_ready=0 for a 5th branch, non-branch still accepted. Correct resolve id 0 -> ckpt_count=3.
- Assert rst mid-stream -> RMT identity, free_count=32, out_valid=0 next cycle.

Source files
------------

// File: rtl/rename_checkpoint_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : rename_checkpoint_unit_if
// Purpose  : Rename request / renamed-result bundle between decode and renamer
// Revision : 1.0 - initial release
// ============================================================================
interface rename_checkpoint_unit_if #(
    parameter int NUM_ARCH_REGS = 32,
    parameter int NUM_PHYS_REGS = 64,
    parameter int NUM_CKPTS     = 4
);
    localparam int AW = $clog2(NUM_ARCH_REGS);
    localparam int PW = $clog2(NUM_PHYS_REGS);
    localparam int CW = $clog2(NUM_CKPTS);

    logic          ren_valid;
    logic          ren_uses_rw;
    logic          ren_ckpt;
    logic [AW-1:0] ren_rs_arch;
    logic [AW-1:0] ren_rt_arch;
    logic [AW-1:0] ren_rw_arch;
    logic          ren_ready;

    logic          out_valid;
    logic [PW-1:0] out_rs_phys;
    logic [PW-1:0] out_rt_phys;
    logic [PW-1:0] out_rw_phys;
    logic [PW-1:0] out_old_phys;
    logic          out_rs_busy;
    logic          out_rt_busy;
    logic [CW-1:0] out_ckpt_id;

    modport master (
        output ren_valid, ren_uses_rw, ren_ckpt, ren_rs_arch, ren_rt_arch, ren_rw_arch,
        input  ren_ready,
        input  out_valid, out_rs_phys, out_rt_phys, out_rw_phys, out_old_phys,
        input  out_rs_busy, out_rt_busy, out_ckpt_id
    );

    modport slave (
        input  ren_valid, ren_uses_rw, ren_ckpt, ren_rs_arch, ren_rt_arch, ren_rw_arch,
        output ren_ready,
        output out_valid, out_rs_phys, out_rt_phys, out_rw_phys, out_old_phys,
        output out_rs_busy, out_rt_busy, out_ckpt_id
    );
endinterface
`default_nettype wire

// File: rtl/rename_checkpoint_unit.sv
`default_nettype none
// ============================================================================
// Module   : rename_checkpoint_unit
// Purpose  : Register renamer with circular free list, busy table and branch
//            checkpoints giving single-cycle mispredict recovery
// Revision : 1.0 - initial release
// ============================================================================
module rename_checkpoint_unit #(
    parameter int  NUM_ARCH_REGS = 32,
    parameter int  NUM_PHYS_REGS = 64,
    parameter int  NUM_CKPTS     = 4,
    localparam int AW = $clog2(NUM_ARCH_REGS),
    localparam int PW = $clog2(NUM_PHYS_REGS),
    localparam int CW = $clog2(NUM_CKPTS)
) (
    input  wire                 clk,
    input  wire                 rst,
    rename_checkpoint_unit_if.slave ren_if,
    input  wire                 wb_valid,
    input  wire  [PW-1:0]       wb_phys,
    input  wire                 cm_valid,
    input  wire  [PW-1:0]       cm_old_phys,
    input  wire                 br_valid,
    input  wire                 br_mispredict,
    input  wire  [CW-1:0]       br_ckpt_id,
    output logic [PW:0]         free_count,
    output logic [CW:0]         ckpt_count
);
    localparam int          C_INIT_FREE = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam logic [PW:0] C_FREE_FULL = (PW+1)'(NUM_PHYS_REGS);
    localparam logic [CW:0] C_CKPT_FULL = (CW+1)'(NUM_CKPTS);

    logic [PW-1:0]            r_rmt      [NUM_ARCH_REGS];
    logic [PW-1:0]            r_free     [NUM_PHYS_REGS];
    logic [PW:0]              r_rd_ptr, r_wr_ptr;
    logic [NUM_PHYS_REGS-1:0] r_busy;
    logic [PW-1:0]            r_ckpt_rmt [NUM_CKPTS][NUM_ARCH_REGS];
    logic [PW:0]              r_ckpt_rd  [NUM_CKPTS];
    logic [CW:0]              r_ckpt_head, r_ckpt_tail;

    logic          r_out_valid, r_out_rs_busy, r_out_rt_busy;
    logic [PW-1:0] r_out_rs_phys, r_out_rt_phys, r_out_rw_phys, r_out_old_phys;
    logic [CW-1:0] r_out_ckpt_id;

    logic                     w_mispredict, w_resolve_ok, w_ready, w_accept, w_alloc, w_take_ckpt;
    logic [PW-1:0]            w_rs_phys, w_rt_phys, w_old_phys, w_new_phys;
    logic [PW:0]              w_rd_ptr_pop;
    logic [CW-1:0]            w_tail_idx, w_dist;
    logic [CW:0]              w_tail_restore;
    logic [PW-1:0]            w_rmt_upd  [NUM_ARCH_REGS];
    logic [NUM_PHYS_REGS-1:0] w_busy_nxt;

    assign free_count   = r_wr_ptr - r_rd_ptr;
    assign ckpt_count   = r_ckpt_tail - r_ckpt_head;

    assign w_mispredict = br_valid & br_mispredict;
    assign w_resolve_ok = br_valid & ~br_mispredict;
    assign w_ready      = ~w_mispredict
                        & (~ren_if.ren_uses_rw | (free_count != '0))
                        & (~ren_if.ren_ckpt    | (ckpt_count != C_CKPT_FULL));
    assign w_accept     = ren_if.ren_valid & w_ready;
    assign w_alloc      = w_accept & ren_if.ren_uses_rw;
    assign w_take_ckpt  = w_accept & ren_if.ren_ckpt;

    assign w_rs_phys    = r_rmt[ren_if.ren_rs_arch];
    assign w_rt_phys    = r_rmt[ren_if.ren_rt_arch];
    assign w_old_phys   = r_rmt[ren_if.ren_rw_arch];
    assign w_new_phys   = r_free[r_rd_ptr[PW-1:0]];
    assign w_rd_ptr_pop = r_rd_ptr + (PW+1)'(w_alloc);
    assign w_tail_idx   = r_ckpt_tail[CW-1:0];

    // Rebuild the tail with its wrap bit: it lands one past the flushed slot.
    assign w_dist         = br_ckpt_id - r_ckpt_head[CW-1:0];
    assign w_tail_restore = r_ckpt_head + {1'b0, w_dist} + (CW+1)'(1);

    always_comb begin
        w_rmt_upd = r_rmt;
        if (w_alloc) begin
            w_rmt_upd[ren_if.ren_rw_arch] = w_new_phys;
        end
    end

    // Writeback clear first so a same-cycle allocation of that reg wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_valid) begin
            w_busy_nxt[wb_phys] = 1'b0;
        end
        if (w_alloc) begin
            w_busy_nxt[w_new_phys] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                r_rmt[i] <= PW'(i);
            end
            for (int i = 0; i < NUM_PHYS_REGS; i++) begin
                r_free[i] <= (i < C_INIT_FREE) ? PW'(NUM_ARCH_REGS + i) : '0;
            end
            r_rd_ptr    <= '0;
            r_wr_ptr    <= (PW+1)'(C_INIT_FREE);
            r_busy      <= '0;
            r_ckpt_head <= '0;
            r_ckpt_tail <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (cm_valid) begin
                r_free[r_wr_ptr[PW-1:0]] <= cm_old_phys;
                r_wr_ptr                 <= r_wr_ptr + (PW+1)'(1);
            end
            if (w_mispredict) begin
                r_rmt       <= r_ckpt_rmt[br_ckpt_id];
                r_rd_ptr    <= r_ckpt_rd[br_ckpt_id];
                r_ckpt_tail <= w_tail_restore;
            end else begin
                r_rmt    <= w_rmt_upd;
                r_rd_ptr <= w_rd_ptr_pop;
                if (w_take_ckpt) begin
                    r_ckpt_tail <= r_ckpt_tail + (CW+1)'(1);
                end
            end
            if (w_resolve_ok) begin
                r_ckpt_head <= r_ckpt_head + (CW+1)'(1);
            end
        end
    end

    // Slot contents are meaningless until taken, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_take_ckpt) begin
            r_ckpt_rmt[w_tail_idx] <= w_rmt_upd;
            r_ckpt_rd[w_tail_idx]  <= w_rd_ptr_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_rs_phys  <= '0;
            r_out_rt_phys  <= '0;
            r_out_rw_phys  <= '0;
            r_out_old_phys <= '0;
            r_out_rs_busy  <= 1'b0;
            r_out_rt_busy  <= 1'b0;
            r_out_ckpt_id  <= '0;
        end else begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_rs_phys  <= w_rs_phys;
                r_out_rt_phys  <= w_rt_phys;
                r_out_rw_phys  <= ren_if.ren_uses_rw ? w_new_phys : '0;
                r_out_old_phys <= ren_if.ren_uses_rw ? w_old_phys : '0;
                r_out_rs_busy  <= r_busy[w_rs_phys] & ~(wb_valid & (wb_phys == w_rs_phys));
                r_out_rt_busy  <= r_busy[w_rt_phys] & ~(wb_valid & (wb_phys == w_rt_phys));
                r_out_ckpt_id  <= ren_if.ren_ckpt ? w_tail_idx : '0;
            end
        end
    end

    assign ren_if.ren_ready    = w_ready;
    assign ren_if.out_valid    = r_out_valid;
    assign ren_if.out_rs_phys  = r_out_rs_phys;
    assign ren_if.out_rt_phys  = r_out_rt_phys;
    assign ren_if.out_rw_phys  = r_out_rw_phys;
    assign ren_if.out_old_phys = r_out_old_phys;
    assign ren_if.out_rs_busy  = r_out_rs_busy;
    assign ren_if.out_rt_busy  = r_out_rt_busy;
    assign ren_if.out_ckpt_id  = r_out_ckpt_id;

    a_commit_overflow: assert property (@(posedge clk) disable iff (rst)
        !(cm_valid && (free_count == C_FREE_FULL)));
    a_inorder_resolve: assert property (@(posedge clk) disable iff (rst)
        !(w_resolve_ok && (br_ckpt_id != r_ckpt_head[CW-1:0])));
endmodule
`default_nettype wire

// File: tb/tb_rename_checkpoint_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rename_checkpoint_unit
// Purpose  : Directed scoreboard bench for the rename/checkpoint unit
// Revision : 1.0 - initial release
// ============================================================================
module tb_rename_checkpoint_unit;
    localparam int NA = 32;
    localparam int NP = 64;
    localparam int NC = 4;
    localparam int AW = 5;
    localparam int PW = 6;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid, cm_valid, br_valid, br_mispredict;
    logic [PW-1:0] wb_phys, cm_old_phys;
    logic [CW-1:0] br_ckpt_id;
    logic [PW:0]   free_count;
    logic [CW:0]   ckpt_count;

    always #5 clk = ~clk;

    rename_checkpoint_unit_if #(.NUM_ARCH_REGS(NA), .NUM_PHYS_REGS(NP), .NUM_CKPTS(NC)) rif ();

    rename_checkpoint_unit #(.NUM_ARCH_REGS(NA), .NUM_PHYS_REGS(NP), .NUM_CKPTS(NC)) dut (
        .clk           (clk),
        .rst           (rst),
        .ren_if        (rif),
        .wb_valid      (wb_valid),
        .wb_phys       (wb_phys),
        .cm_valid      (cm_valid),
        .cm_old_phys   (cm_old_phys),
        .br_valid      (br_valid),
        .br_mispredict (br_mispredict),
        .br_ckpt_id    (br_ckpt_id),
        .free_count    (free_count),
        .ckpt_count    (ckpt_count)
    );

    typedef struct {
        logic [PW-1:0] rs, rt, rw, old;
        logic          rsb, rtb, has_ck;
        logic [CW-1:0] ck;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every presented result must match the oldest expectation.
    always @(negedge clk) begin
        if (rif.out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual=out_valid required=no_output");
            end else begin
                mon_e = sbq.pop_front();
                chk("out_rs_phys",  32'(rif.out_rs_phys),  32'(mon_e.rs));
                chk("out_rt_phys",  32'(rif.out_rt_phys),  32'(mon_e.rt));
                chk("out_rw_phys",  32'(rif.out_rw_phys),  32'(mon_e.rw));
                chk("out_old_phys", 32'(rif.out_old_phys), 32'(mon_e.old));
                chk("out_rs_busy",  32'(rif.out_rs_busy),  32'(mon_e.rsb));
                chk("out_rt_busy",  32'(rif.out_rt_busy),  32'(mon_e.rtb));
                if (mon_e.has_ck) chk("out_ckpt_id", 32'(rif.out_ckpt_id), 32'(mon_e.ck));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        rif.ren_valid   = 1'b0;
        rif.ren_uses_rw = 1'b0;
        rif.ren_ckpt    = 1'b0;
        wb_valid        = 1'b0;
        cm_valid        = 1'b0;
        br_valid        = 1'b0;
        br_mispredict   = 1'b0;
    endtask

    task automatic ren(input bit rw_en, input bit ck, input int rs, input int rt, input int rw,
                       input bit exp_rdy, input int ers, input int ert, input int erw,
                       input int eold, input bit ersb, input bit ertb, input int eck);
        exp_t e;
        rif.ren_valid   = 1'b1;
        rif.ren_uses_rw = rw_en;
        rif.ren_ckpt    = ck;
        rif.ren_rs_arch = AW'(rs);
        rif.ren_rt_arch = AW'(rt);
        rif.ren_rw_arch = AW'(rw);
        #1;
        chk("ren_ready", 32'(rif.ren_ready), 32'(exp_rdy));
        if (exp_rdy) begin
            e.rs = PW'(ers); e.rt = PW'(ert); e.rw = PW'(erw); e.old = PW'(eold);
            e.rsb = ersb; e.rtb = ertb; e.has_ck = ck; e.ck = CW'(eck);
            sbq.push_back(e);
        end
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid",  32'(rif.out_valid), 32'd0);
        chk("rst_free_count", 32'(free_count),    32'd32);
        chk("rst_ckpt_count", 32'(ckpt_count),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        rif.ren_valid = 1'b0; rif.ren_uses_rw = 1'b0; rif.ren_ckpt = 1'b0;
        rif.ren_rs_arch = '0; rif.ren_rt_arch = '0; rif.ren_rw_arch = '0;
        wb_valid = 1'b0; wb_phys = '0; cm_valid = 1'b0; cm_old_phys = '0;
        br_valid = 1'b0; br_mispredict = 1'b0; br_ckpt_id = '0;
        @(negedge clk);
        do_reset();

        // add r3 <- r1, r2
        ren(1, 0, 1, 2, 3, 1, 1, 2, 32, 3, 0, 0, 0);
        chk("free_after_add", 32'(free_count), 32'd31);

        // r5 <- r5,r0 then reads of r5, writeback bypass, set-beats-clear
        do_reset();
        ren(1, 0, 5, 0, 5, 1, 5, 0, 32, 5, 0, 0, 0);
        ren(0, 0, 5, 0, 0, 1, 32, 0, 0, 0, 1, 0, 0);
        wb_valid = 1'b1; wb_phys = PW'(32);
        ren(0, 0, 5, 0, 0, 1, 32, 0, 0, 0, 0, 0, 0);
        ren(0, 0, 5, 0, 0, 1, 32, 0, 0, 0, 0, 0, 0);
        wb_valid = 1'b1; wb_phys = PW'(33);
        ren(1, 0, 0, 0, 7, 1, 0, 0, 33, 7, 0, 0, 0);
        ren(0, 0, 7, 0, 0, 1, 33, 0, 0, 0, 1, 0, 0);

        // exhaust the free list, then refill with one commit
        do_reset();
        for (int i = 0; i < 32; i++)
            ren(1, 0, i, 0, i, 1, i, (i == 0) ? 0 : 32, 32 + i, i, 0, (i != 0), 0);
        chk("free_empty", 32'(free_count), 32'd0);
        ren(1, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        ren(0, 0, 3, 1, 0, 1, 35, 33, 0, 0, 1, 1, 0);
        cm_valid = 1'b1; cm_old_phys = PW'(3);
        ren(1, 0, 3, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("free_after_commit", 32'(free_count), 32'd1);
        ren(1, 0, 3, 1, 3, 1, 35, 33, 3, 35, 1, 1, 0);
        chk("free_reempty", 32'(free_count), 32'd0);

        // checkpoint, younger renames, mispredict with simultaneous commit
        do_reset();
        ren(1, 1, 0, 0, 1, 1, 0, 0, 32, 1, 0, 0, 0);
        ren(1, 0, 1, 0, 1, 1, 32, 0, 33, 32, 1, 0, 0);
        ren(1, 0, 1, 0, 2, 1, 33, 0, 34, 2, 1, 0, 0);
        chk("ckpt_live", 32'(ckpt_count), 32'd1);
        chk("free_pre_flush", 32'(free_count), 32'd29);
        br_valid = 1'b1; br_mispredict = 1'b1; br_ckpt_id = CW'(0);
        cm_valid = 1'b1; cm_old_phys = PW'(5);
        ren(1, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("free_post_flush", 32'(free_count), 32'd32);
        chk("ckpt_post_flush", 32'(ckpt_count), 32'd1);
        ren(1, 0, 1, 2, 1, 1, 32, 2, 33, 32, 1, 0, 0);
        br_valid = 1'b1; br_ckpt_id = CW'(0);
        tick();
        chk("ckpt_resolved", 32'(ckpt_count), 32'd0);

        // checkpoint stack full, wrap and partial flush
        do_reset();
        for (int i = 0; i < 4; i++) ren(0, 1, i, 0, 0, 1, i, 0, 0, 0, 0, 0, i);
        chk("ckpt_full", 32'(ckpt_count), 32'd4);
        ren(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ren(0, 0, 1, 2, 0, 1, 1, 2, 0, 0, 0, 0, 0);
        br_valid = 1'b1; br_ckpt_id = CW'(0);
        tick();
        chk("ckpt_after_resolve", 32'(ckpt_count), 32'd3);
        ren(0, 1, 4, 5, 0, 1, 4, 5, 0, 0, 0, 0, 0);
        chk("ckpt_wrapped", 32'(ckpt_count), 32'd4);
        br_valid = 1'b1; br_mispredict = 1'b1; br_ckpt_id = CW'(2);
        tick();
        chk("ckpt_partial_flush", 32'(ckpt_count), 32'd2);
        ren(0, 1, 6, 7, 0, 1, 6, 7, 0, 0, 0, 0, 3);

        // reset in mid-stream
        do_reset();
        ren(1, 0, 0, 0, 1, 1, 0, 0, 32, 1, 0, 0, 0);
        ren(1, 1, 1, 0, 2, 1, 32, 0, 33, 2, 1, 0, 0);
        rst = 1'b1;
        rif.ren_valid = 1'b1; rif.ren_uses_rw = 1'b1; rif.ren_rw_arch = AW'(5);
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", 32'(rif.out_valid), 32'd0);
        chk("midrst_free",      32'(free_count),    32'd32);
        chk("midrst_ckpt",      32'(ckpt_count),    32'd0);
        ren(1, 0, 1, 2, 1, 1, 1, 2, 32, 1, 0, 0, 0);

        tick();
        tick();
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
